mips_bus_arbiter: RTL and testbench
===================================

MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 SHALL have parameter N_RD, default 2, number of read channels (1..8).
REQ-002 SHALL have parameter WB_STARVE_MAX, default 3, max consecutive read grants while a write is pending (0 = write always first).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rd_req  in  N_RD  per-channel read request, held until its rd_valid.
REQ-006 rd_addr  in  32*N_RD  flattened read addresses; channel i at [32*i+31:32*i].
REQ-007 rd_valid  out  N_RD  one-hot pulse: read data for channel i valid this cycle.
REQ-008 rd_rdata  out  32  read data shared by all channels, equal to mem_readdata.
REQ-009 wr_req, wr_addr, wr_data, wr_be  in  1/32/32/4  write-buffer head entry, held until wr_ack.
REQ-010 wr_ack  out  1  pulse: head write accepted by memory; buffer pops this cycle.
REQ-011 mem_address, mem_read, mem_write, mem_writedata, mem_byteenable  out  32/1/1/32/4  Avalon master command.
REQ-012 mem_waitrequest, mem_readdata  in  1/32  Avalon slave response.
REQ-013 busy  out  1  high when state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, READ, WRITE.
REQ-015 IDLE: arbitrate on sampled requests; winner address/data/be latched; next state READ or WRITE; no requests -> stay IDLE.
REQ-016 Write wins if wr_req and (no rd_req, or starve_cnt == WB_STARVE_MAX); else read arbitration per REQ-027/028.
REQ-017 starve_cnt: +1 per read grant while wr_req high; cleared on write grant or when wr_req low; saturates at WB_STARVE_MAX.
REQ-018 READ: mem_read=1, mem_address=latched address, mem_byteenable=4'b1111, held stable while mem_waitrequest=1.
REQ-019 READ with mem_waitrequest=0: rd_valid[granted]=1 combinationally that cycle; next state IDLE.
REQ-020 WRITE: mem_write=1, mem_address/mem_writedata/mem_byteenable = latched wr_addr/wr_data/wr_be, held while mem_waitrequest=1.
REQ-021 WRITE with mem_waitrequest=0: wr_ack=1 that cycle; next state IDLE.
REQ-022 Minimum latency: request high in IDLE cycle N -> command on bus cycle N+1 -> rd_valid/wr_ack earliest cycle N+1; one IDLE cycle between transactions.
REQ-023 mem_read and mem_write never high together; IDLE drives both 0, mem_byteenable 4'b0000.
REQ-024 Requester dropping rd_req mid-transaction: transaction still completes and rd_valid still pulses; no abort on Avalon.
REQ-025 Changes to rd_addr/wr_* after grant SHALL NOT affect the bus (latched values used).
REQ-026 Simultaneous rd_req on all channels and wr_req with starve_cnt below limit: read granted, starve_cnt increments.

Configuration
REQ-027 With macro MIPS_ARB_RR_EN defined: round-robin read arbitration; pointer = last granted channel; grant first requesting channel after pointer, cyclically; pointer updates only on read grant; reset pointer N_RD-1 (channel 0 first).
REQ-028 Without MIPS_ARB_RR_EN: fixed priority, lowest index wins; no pointer register.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, mem_read 0, mem_write 0, mem_address 0, mem_writedata 0, mem_byteenable 0, rd_valid 0, wr_ack 0, busy 0, starve_cnt 0.
REQ-030 Reset mid-transaction abandons the Avalon access; no rd_valid/wr_ack issued for it after release.
REQ-031 First arbitration SHALL occur in the first clock edge after rst_n deasserts.

Verification
REQ-032 Single read: rd_req=01, rd_addr[0]=0x100, waitrequest 2 cycles -> mem_read held 3 cycles at 0x100, rd_valid=01 in last, rd_rdata=mem_readdata.
REQ-033 Write: wr_req, wr_addr=0x200, wr_data=0xDEADBEEF, wr_be=0011, waitrequest 0 -> mem_write one cycle with those values, wr_ack same cycle.
REQ-034 Starvation: WB_STARVE_MAX=3, rd_req=01 and wr_req held -> grants R,R,R,W; starve_cnt back to 0 after W.
REQ-035 RR (MIPS_ARB_RR_EN): N_RD=3, rd_req=111 held -> grant order 0,1,2,0; without macro -> 0,0,0,0.
REQ-036 Reset: rst_n low during READ with waitrequest=1 -> mem_read 0 immediately; after release no rd_valid until a new request.
REQ-037 Addr change: rd_addr[1] changed from 0x10 to 0x20 during READ -> mem_address stays 0x10.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: arbitrates N_RD read channels and one write-buffer head
// onto a single Avalon-MM master port. One transaction at a time, with an
// IDLE cycle between transactions.
// Optional feature macro: MIPS_ARB_RR_EN. When it is defined, reads are
// arbitrated round-robin. Otherwise the lowest read index wins.
module mips_bus_arbiter #(
  parameter int N_RD          = 2,
  parameter int WB_STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_RD-1:0]     rd_req,
  input  logic [32*N_RD-1:0]  rd_addr,
  output logic [N_RD-1:0]     rd_valid,
  output logic [31:0]         rd_rdata,
  input  logic                wr_req,
  input  logic [31:0]         wr_addr,
  input  logic [31:0]         wr_data,
  input  logic [3:0]          wr_be,
  output logic                wr_ack,
  output logic [31:0]         mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [31:0]         mem_writedata,
  output logic [3:0]          mem_byteenable,
  input  logic                mem_waitrequest,
  input  logic [31:0]         mem_readdata,
  output logic                busy
);

  localparam int IW = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int SW = (WB_STARVE_MAX < 2) ? 1 : $clog2(WB_STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                  state, state_nxt;
  logic [31:0]             lat_addr, lat_data;
  logic [3:0]              lat_be;
  logic [IW-1:0]           lat_ch;
  logic [SW-1:0]           starve_cnt;
  logic [IW-1:0]           rd_sel;
  logic                    rd_any, wr_win, rd_gnt, wr_gnt;
  logic [N_RD-1:0][31:0]   rd_addr_v;

  assign rd_addr_v = rd_addr;
  assign rd_any    = |rd_req;
  // A pending write goes first when no read competes, or once reads have
  // used up their allowed consecutive grants.
  assign wr_win    = wr_req && (!rd_any || starve_cnt == SW'(WB_STARVE_MAX));
  assign wr_gnt    = (state == IDLE) && wr_win;
  assign rd_gnt    = (state == IDLE) && !wr_win && rd_any;

`ifdef MIPS_ARB_RR_EN
  logic [IW-1:0] rr_ptr;
  logic          rr_found;

  // Round-robin pick: first requester above the pointer, else wrap to the lowest.
  always_comb begin
    rd_sel   = '0;
    rr_found = 1'b0;
    for (int i = 0; i < N_RD; i++)
      if (!rr_found && rd_req[i] && IW'(i) > rr_ptr) begin
        rd_sel   = IW'(i);
        rr_found = 1'b1;
      end
    for (int i = 0; i < N_RD; i++)
      if (!rr_found && rd_req[i]) begin
        rd_sel   = IW'(i);
        rr_found = 1'b1;
      end
  end

  // The pointer tracks the last granted read channel. It resets to the top
  // channel so that channel 0 is served first.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      rr_ptr <= IW'(N_RD - 1);
    else if (rd_gnt) rr_ptr <= rd_sel;
`else
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    rd_sel = '0;
    for (int i = N_RD - 1; i >= 0; i--)
      if (rd_req[i]) rd_sel = IW'(i);
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Next state: grant from IDLE, and return to IDLE when the slave accepts.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_win) state_nxt = WRITE;
               else if (rd_any) state_nxt = READ;
      READ:    if (!mem_waitrequest) state_nxt = IDLE;
      WRITE:   if (!mem_waitrequest) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winner's command at grant. Later input changes cannot reach the bus.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lat_addr <= '0;
      lat_data <= '0;
      lat_be   <= '0;
      lat_ch   <= '0;
    end else if (wr_gnt) begin
      lat_addr <= wr_addr;
      lat_data <= wr_data;
      lat_be   <= wr_be;
    end else if (rd_gnt) begin
      lat_addr <= rd_addr_v[rd_sel];
      lat_ch   <= rd_sel;
    end

  // Count consecutive read grants taken while a write waits. The count
  // saturates at the limit and clears on a write grant or when no write is pending.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                       starve_cnt <= '0;
    else if (!wr_req || wr_gnt)                       starve_cnt <= '0;
    else if (rd_gnt && starve_cnt != SW'(WB_STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;

  // Bus outputs decode from state only. The async reset to IDLE therefore
  // forces all of them low at once.
  always_comb begin
    mem_read       = (state == READ);
    mem_write      = (state == WRITE);
    mem_address    = (state != IDLE)  ? lat_addr : 32'h0;
    mem_writedata  = (state == WRITE) ? lat_data : 32'h0;
    mem_byteenable = (state == READ)  ? 4'b1111 :
                     (state == WRITE) ? lat_be  : 4'b0000;
    wr_ack         = (state == WRITE) && !mem_waitrequest;
    busy           = (state != IDLE);
    rd_rdata       = mem_readdata;
    rd_valid       = '0;
    for (int i = 0; i < N_RD; i++)
      rd_valid[i] = (state == READ) && !mem_waitrequest && (lat_ch == IW'(i));
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter (N_RD=3, WB_STARVE_MAX=3).
// It checks the default fixed-priority build, or round-robin when MIPS_ARB_RR_EN is defined.
module tb_mips_bus_arbiter;
  localparam int N_RD = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_RD-1:0]   rd_req = '0;
  logic [32*N_RD-1:0] rd_addr = '0;
  logic [N_RD-1:0]   rd_valid;
  logic [31:0]       rd_rdata;
  logic              wr_req = 1'b0;
  logic [31:0]       wr_addr = '0, wr_data = '0;
  logic [3:0]        wr_be = '0;
  logic              wr_ack;
  logic [31:0]       mem_address, mem_writedata;
  logic              mem_read, mem_write;
  logic [3:0]        mem_byteenable;
  logic              mem_waitrequest = 1'b0;
  logic [31:0]       mem_readdata = '0;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [N_RD-1:0] rr_exp [4];
  logic [N_RD-1:0] mix_exp;

  mips_bus_arbiter #(.N_RD(N_RD), .WB_STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle. The new cycle starts 1ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef MIPS_ARB_RR_EN
    rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001};
    mix_exp = 3'b010;
`else
    rr_exp  = '{3'b001, 3'b001, 3'b001, 3'b001};
    mix_exp = 3'b001;
`endif

    // Reset state
    #2;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_be", mem_byteenable, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_busy", busy, 0);
    tick; tick;
    rst_n = 1'b1;

    // Single read on channel 0 with two wait cycles
    rd_req = 3'b001; rd_addr[31:0] = 32'h100; mem_waitrequest = 1'b1;
    #1 chk("rd_idle_busy", busy, 0);
    tick;
    chk("rd_c1_read", mem_read, 1);
    chk("rd_c1_addr", mem_address, 32'h100);
    chk("rd_c1_be", mem_byteenable, 4'hF);
    chk("rd_c1_valid", rd_valid, 0);
    chk("rd_c1_write", mem_write, 0);
    tick;
    chk("rd_c2_read", mem_read, 1);
    chk("rd_c2_addr", mem_address, 32'h100);
    tick;
    mem_waitrequest = 1'b0; mem_readdata = 32'hCAFEF00D; rd_req = '0;
    #1;
    chk("rd_c3_read", mem_read, 1);
    chk("rd_c3_valid", rd_valid, 3'b001);
    chk("rd_c3_rdata", rd_rdata, 32'hCAFEF00D);
    tick;
    chk("rd_idle_read", mem_read, 0);
    chk("rd_idle_valid", rd_valid, 0);
    chk("rd_idle_be", mem_byteenable, 0);

    // Single write, no wait
    wr_req = 1'b1; wr_addr = 32'h200; wr_data = 32'hDEADBEEF; wr_be = 4'b0011;
    #1 chk("wr_idle_ack", wr_ack, 0);
    tick;
    chk("wr_write", mem_write, 1);
    chk("wr_read", mem_read, 0);
    chk("wr_addr", mem_address, 32'h200);
    chk("wr_data", mem_writedata, 32'hDEADBEEF);
    chk("wr_be", mem_byteenable, 4'b0011);
    chk("wr_ack", wr_ack, 1);
    wr_req = 1'b0;
    tick;
    chk("wr_idle_write", mem_write, 0);
    chk("wr_idle_ack2", wr_ack, 0);

    // Starvation: the grant pattern R,R,R,W repeats, so the count cleared after W
    rd_req = 3'b001; wr_req = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick;
      chk($sformatf("starve_rd%0d", t), mem_read, (t == 3 || t == 7) ? 0 : 1);
      chk($sformatf("starve_wr%0d", t), mem_write, (t == 3 || t == 7) ? 1 : 0);
      if (t == 7) begin rd_req = '0; wr_req = 1'b0; end
      tick;
    end

    // Address change after grant, then reset mid-read
    rd_req = 3'b010; rd_addr[63:32] = 32'h10; mem_waitrequest = 1'b1;
    tick;
    chk("ach_read", mem_read, 1);
    chk("ach_addr1", mem_address, 32'h10);
    rd_addr[63:32] = 32'h20;
    tick;
    chk("ach_addr2", mem_address, 32'h10);
    rst_n = 1'b0;
    #1;
    chk("mrst_read", mem_read, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_addr", mem_address, 0);
    chk("mrst_be", mem_byteenable, 0);
    rd_req = '0; mem_waitrequest = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick;
      chk($sformatf("post_rst_valid%0d", t), rd_valid, 0);
      chk($sformatf("post_rst_busy%0d", t), busy, 0);
    end

    // All read channels held: order depends on the arbitration mode
    rd_req = 3'b111; rd_addr = {32'h300, 32'h200, 32'h100};
    for (int t = 0; t < 4; t++) begin
      tick;
      chk($sformatf("rr_valid%0d", t), rd_valid, rr_exp[t]);
      tick;
    end

    // All reads plus a write with the starve count below the limit: a read wins
    wr_req = 1'b1;
    tick;
    chk("mix_read", mem_read, 1);
    chk("mix_write", mem_write, 0);
    chk("mix_valid", rd_valid, mix_exp);
    rd_req = '0; wr_req = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
